// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle word ALU.
// No logic here: constants only.
// Imported by alu_mc and alu_mod_unit.
package alu_pkg;

    // 3-bit ALU opcodes
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    // Controller FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mod_unit.sv
// Iterative unsigned remainder, restoring shift-subtract, one quotient bit per cycle.
// Latency: WIDTH iterations after load; remainder/last are combinational views of the current step.
// No backpressure: load restarts unconditionally, the unit idles once WIDTH steps are done.
module alu_mod_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;        // WIDTH+1-bit partial remainder before the trial subtract
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;

    // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
    // The stored remainder is always < divisor, so the restored value fits in WIDTH bits.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // The top latches the final step's remainder on the same edge that completes it.
    assign remainder = rem_step;
    assign last      = (cnt_q == CW'(WIDTH - 1));

    // Next state: load clears the remainder and latches operands, then step until WIDTH bits consumed.
    always_comb begin
        rem_d = rem_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = '0;
            dvd_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (cnt_q != CW'(WIDTH)) begin
            rem_d = rem_step;
            dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Datapath registers; the counter parks at WIDTH after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            cnt_q <= CW'(WIDTH);
        end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle word ALU: logic/add/sub/slt in one step, unsigned mod by iterative remainder.
// Latency: done 1 cycle after accept, WIDTH+1 cycles for mod with nonzero divisor.
// start is only sampled while idle; requests while busy are dropped, not queued.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             div_zero
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cy_q, cy_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             sub_mode;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum;
    logic             add_cout;
    logic             add_v;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_cy;
    logic             alu_dz;

    logic             mod_load;
    logic [WIDTH-1:0] mod_rem;
    logic             mod_last;

    assign accept = start && (state_q == ST_IDLE);

    // Shared adder: sub and slt both compute a + ~b + 1.
    assign sub_mode = (alu_op == OP_SUB) || (alu_op == OP_SLT);
    assign b_add    = sub_mode ? ~b : b;
    assign add_full = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub_mode};
    assign sum      = add_full[WIDTH-1:0];
    assign add_cout = add_full[WIDTH];
    // Same-sign inputs producing a differently-signed sum: equals carry-in-to-MSB xor carry-out.
    assign add_v    = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // Single-step result and flags; the mod entry only applies to the divide-by-zero case.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cy  = 1'b0;
        alu_dz  = 1'b0;
        case (alu_op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_v};
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = add_v;
                alu_cy  = add_cout;
            end
            OP_MOD: begin
                alu_res = a;
                alu_dz  = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    assign mod_load = accept && (alu_op == OP_MOD) && (b != '0);

    alu_mod_unit #(
        .WIDTH (WIDTH)
    ) u_mod (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mod_load),
        .dividend  (a),
        .divisor   (b),
        .remainder (mod_rem),
        .last      (mod_last)
    );

    // FSM next state; result and flags change only on the transition into DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cy_d     = cy_q;
        dz_d     = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mod_load) begin
                        state_d = ST_MOD;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        cy_d     = alu_cy;
                        dz_d     = alu_dz;
                    end
                end
            end
            ST_MOD: begin
                if (mod_last) begin
                    state_d  = ST_DONE;
                    result_d = mod_rem;
                    zero_d   = (mod_rem == '0);
                    ovf_d    = 1'b0;
                    cy_d     = 1'b0;
                    dz_d     = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cy_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cy_q     <= cy_d;
            dz_q     <= dz_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cy_q;
    assign div_zero  = dz_q;
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, corner sequences, random ops vs model.
// Latency is measured from the accept edge to the done cycle.
// Inputs are driven 1ns after the rising edge; outputs are sampled there too.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    alu_op;
    logic [W-1:0]  a, b;
    logic [W-1:0]  result;
    logic          done, busy, zero, overflow, carry_out, div_zero;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        v;
        logic        c;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        v;
        logic        c;
        logic        dz;
        int          lat;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on wide signed/unsigned values.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, s;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        e.res = '0; e.v = 0; e.c = 0; e.dz = 0; e.lat = 1;
        case (op)
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_XOR: e.res = x ^ y;
            OP_NOR: e.res = ~(x | y);
            OP_SLT: e.res = (sx < sy) ? 32'd1 : 32'd0;
            OP_ADD: begin
                e.res = x + y;
                s     = sx + sy;
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.c   = (ux + uy) > 64'd4294967295;
            end
            OP_SUB: begin
                e.res = x - y;
                s     = sx - sy;
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.c   = (x >= y);
            end
            default: begin
                if (y == 0) begin
                    e.res = x;
                    e.dz  = 1;
                end else begin
                    e.res = x % y;
                    e.lat = W + 1;
                end
            end
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Issue one op (DUT must be idle), optionally poke start mid-operation, wait for done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] ai, input logic [31:0] bi,
                          input int poke, output exp_t got, output logic busy_ok);
        int lat;
        start = 1'b1; alu_op = op; a = ai; b = bi;
        @(posedge clk); #1;
        start = 1'b0; alu_op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (poke != 0 && lat == poke) begin
                start = 1'b1; alu_op = OP_AND; a = $urandom; b = $urandom;
            end
            if (poke != 0 && lat == poke + 2) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        start   = 1'b0;
        got.res = result; got.z = zero; got.v = overflow; got.c = carry_out;
        got.dz  = div_zero; got.lat = lat;
    endtask

    // Compare one completed op against expectations, then check the cycle after done.
    task automatic check_op(input string name, input exp_t got, input exp_t e, input logic busy_ok);
        chk({name, ".lat"},  64'(got.lat), 64'(e.lat));
        chk({name, ".res"},  64'(got.res), 64'(e.res));
        chk({name, ".flags"}, {60'd0, got.z, got.v, got.c, got.dz}, {60'd0, e.z, e.v, e.c, e.dz});
        chk({name, ".busy"}, 64'(busy_ok), 64'd1);
        @(posedge clk); #1;
        chk({name, ".after"}, {30'd0, done, busy, result}, {32'd0, got.res});
    endtask

    vec_t tbl[15];

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t  got, e;
        logic  bok;
        logic  seen;
        logic [2:0]  rop;
        logic [31:0] rx, ry;

        tbl[0]  = '{"and",      OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0, 1};
        tbl[1]  = '{"add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 0, 1};
        tbl[2]  = '{"sub_eq",   OP_SUB, 32'd5,         32'd5,         32'd0,         1, 0, 1, 0, 1};
        tbl[3]  = '{"slt_neg",  OP_SLT, 32'h8000_0000, 32'h0000_0001, 32'd1,         0, 0, 0, 0, 1};
        tbl[4]  = '{"slt_pos",  OP_SLT, 32'h0000_0001, 32'h8000_0000, 32'd0,         1, 0, 0, 0, 1};
        tbl[5]  = '{"mod_100_7",OP_MOD, 32'd100,       32'd7,         32'd2,         0, 0, 0, 0, 33};
        tbl[6]  = '{"mod_div0", OP_MOD, 32'h0000_1234, 32'd0,         32'h0000_1234, 0, 0, 0, 1, 1};
        tbl[7]  = '{"or",       OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0, 0, 0, 1};
        tbl[8]  = '{"xor_self", OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1, 0, 0, 0, 1};
        tbl[9]  = '{"nor_zero", OP_NOR, 32'd0,         32'd0,         32'hFFFF_FFFF, 0, 0, 0, 0, 1};
        tbl[10] = '{"add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 0, 1, 0, 1};
        tbl[11] = '{"sub_brw",  OP_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 0, 0, 0, 0, 1};
        tbl[12] = '{"sub_ovf",  OP_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 0, 1, 1, 0, 1};
        tbl[13] = '{"mod_big",  OP_MOD, 32'hFFFF_FFFF, 32'd16,        32'd15,        0, 0, 0, 0, 33};
        tbl[14] = '{"mod_small",OP_MOD, 32'd3,         32'd7,         32'd3,         0, 0, 0, 0, 33};

        rst_n = 1'b0; start = 1'b0; alu_op = 3'd0; a = '0; b = '0;
        #3;
        chk("reset_state", {26'd0, result, done, busy, zero, overflow, carry_out, div_zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, got, bok);
            e.res = tbl[i].res; e.z = tbl[i].z; e.v = tbl[i].v; e.c = tbl[i].c;
            e.dz = tbl[i].dz; e.lat = tbl[i].lat;
            check_op(tbl[i].name, got, e, bok);
        end

        // mod with a start held for two cycles mid-operation: must be ignored
        run_op(OP_MOD, 32'd100, 32'd7, 5, got, bok);
        e = model(OP_MOD, 32'd100, 32'd7);
        check_op("mod_poke", got, e, bok);

        // Reset during cycle 10 of a mod
        start = 1'b1; alu_op = OP_MOD; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("mod_busy_pre_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_mod_reset", {26'd0, result, done, busy, zero, overflow, carry_out, div_zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);
        run_op(OP_ADD, 32'd2, 32'd3, 0, got, bok);
        e = model(OP_ADD, 32'd2, 32'd3);
        chk("add_after_reset_const", 64'(got.res), 64'd5);
        check_op("add_after_reset", got, e, bok);

        // Random ops against the reference model
        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = $urandom;
            ry  = $urandom;
            if (rop == OP_MOD) begin
                case ($urandom_range(0, 3))
                    0: ry = 32'd0;
                    1: ry = 32'($urandom_range(1, 15));
                    default: ry = $urandom;
                endcase
            end else if (rop == OP_SUB && $urandom_range(0, 3) == 0) begin
                ry = rx;
            end
            run_op(rop, rx, ry, 0, got, bok);
            e = model(rop, rx, ry);
            check_op($sformatf("rand%0d_op%0d", n, rop), got, e, bok);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
